// File: rtl/p4_wrapper_pkg.sv
// p4_wrapper_pkg: shared constants for the P4 wrapper sideband logic
package p4_wrapper_pkg;
  localparam int MODE_PASS = 0;
  localparam int MODE_OVERRIDE = 1;
  localparam int SUME_DST_LSB = 24;
  localparam int SUME_DST_WIDTH = 8;
  localparam int SUME_SRC_LSB = 16;
  localparam int DEF_TUSER_WIDTH = 128;
  localparam int DEF_TUPLE_WIDTH = 128;
  localparam int DEF_DEPTH = 16;
endpackage

// File: rtl/tuser_tuple_bridge_if.sv
// tuser_tuple_bridge_if: tapped AXIS handshakes, processor tuple ports and status of the bridge
interface tuser_tuple_bridge_if import p4_wrapper_pkg::*; #(
  parameter int TUSER_WIDTH = DEF_TUSER_WIDTH,
  parameter int TUPLE_WIDTH = DEF_TUPLE_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  logic s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [TUSER_WIDTH-1:0] s_axis_tuser;
  logic proc_in_tvalid, proc_in_tready;
  logic tuple_in_VALID;
  logic [TUPLE_WIDTH-1:0] tuple_in_DATA;
  logic tuple_out_VALID;
  logic [TUPLE_WIDTH-1:0] tuple_out_DATA;
  logic m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [TUSER_WIDTH-1:0] m_axis_tuser;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  logic underflow_err;
  modport master (
    output s_axis_tvalid, s_axis_tlast, s_axis_tuser, proc_in_tready,
    output tuple_out_VALID, tuple_out_DATA, m_axis_tvalid, m_axis_tready, m_axis_tlast,
    input s_axis_tready, proc_in_tvalid, tuple_in_VALID, tuple_in_DATA,
    input m_axis_tuser, fifo_count, underflow_err
  );
  modport slave (
    input s_axis_tvalid, s_axis_tlast, s_axis_tuser, proc_in_tready,
    input tuple_out_VALID, tuple_out_DATA, m_axis_tvalid, m_axis_tready, m_axis_tlast,
    output s_axis_tready, proc_in_tvalid, tuple_in_VALID, tuple_in_DATA,
    output m_axis_tuser, fifo_count, underflow_err
  );
endinterface

// File: rtl/sideband_fifo.sv
// sideband_fifo: synchronous FIFO without fall-through; head reads 0 while empty
module sideband_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign head = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/tuser_tuple_bridge.sv
// tuser_tuple_bridge: carries per-packet tuser across the P4 processor via a SOP-indexed FIFO
module tuser_tuple_bridge import p4_wrapper_pkg::*; #(
  parameter int TUSER_WIDTH = DEF_TUSER_WIDTH,
  parameter int TUPLE_WIDTH = DEF_TUPLE_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int MODE = MODE_PASS,
  parameter int DST_LSB = SUME_DST_LSB,
  parameter int DST_WIDTH = SUME_DST_WIDTH
) (
  input logic clk_line,
  input logic clk_line_rst,
  tuser_tuple_bridge_if.slave bus
);
  logic in_sop, out_sop, full, empty, gate, in_acc, out_acc, push, pop, uf;
  logic [TUSER_WIDTH-1:0] head, live, hold;
  logic unused_tuple;
  assign unused_tuple = ^{bus.tuple_out_VALID, bus.tuple_out_DATA};
  // only a new packet is held back, so a packet never splits from its metadata
  assign gate = in_sop & full;
  assign bus.s_axis_tready = bus.proc_in_tready & ~gate;
  assign bus.proc_in_tvalid = bus.s_axis_tvalid & ~gate;
  assign in_acc = bus.s_axis_tvalid & bus.proc_in_tready & ~gate;
  assign push = in_acc & in_sop & ~clk_line_rst;
  assign out_acc = bus.m_axis_tvalid & bus.m_axis_tready;
  assign pop = out_acc & out_sop & ~empty;
  assign bus.tuple_in_VALID = push;
  assign bus.tuple_in_DATA = push ? TUPLE_WIDTH'(bus.s_axis_tuser) : '0;
  assign bus.m_axis_tuser = out_sop ? live : hold;
  assign bus.underflow_err = uf;
  sideband_fifo #(.WIDTH(TUSER_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk_line), .rst(clk_line_rst), .push(push), .pop(pop), .din(bus.s_axis_tuser),
    .head(head), .count(bus.fifo_count), .full(full), .empty(empty)
  );
  always_comb begin
    live = head;
    if (MODE == MODE_OVERRIDE && bus.tuple_out_VALID && !empty)
      live[DST_LSB +: DST_WIDTH] = bus.tuple_out_DATA[DST_WIDTH-1:0];
  end
  always_ff @(posedge clk_line) begin
    if (clk_line_rst) begin
      in_sop <= 1'b1;
      out_sop <= 1'b1;
      hold <= '0;
      uf <= 1'b0;
    end else begin
      if (in_acc) in_sop <= bus.s_axis_tlast;
      if (out_acc) out_sop <= bus.m_axis_tlast;
      if (out_acc && out_sop) hold <= live;
      if (out_acc && out_sop && empty) uf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_tuser_tuple_bridge.sv
// tb_tuser_tuple_bridge: directed scenarios plus random traffic checked against a queue model
module tb_tuser_tuple_bridge;
  import p4_wrapper_pkg::*;
  localparam int TW = 64, PW = 128, DEPTH = 4;
  localparam int DL = SUME_DST_LSB, DWD = SUME_DST_WIDTH;
  logic clk = 0, rst = 1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  tuser_tuple_bridge_if #(.TUSER_WIDTH(TW), .TUPLE_WIDTH(PW), .DEPTH(DEPTH)) bus ();
  tuser_tuple_bridge #(.TUSER_WIDTH(TW), .TUPLE_WIDTH(PW), .DEPTH(DEPTH), .MODE(MODE_OVERRIDE),
    .DST_LSB(DL), .DST_WIDTH(DWD)) dut (.clk_line(clk), .clk_line_rst(rst), .bus(bus));

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // model: metadata queue plus packet-boundary flags
  logic [TW-1:0] q[$];
  logic in_sop_m = 1, out_sop_m = 1, uf_m = 0;
  logic [TW-1:0] hold_m = '0;

  function automatic logic [TW-1:0] live_m();
    logic [TW-1:0] v;
    if (q.size() == 0) return '0;
    v = q[0];
    if (bus.tuple_out_VALID) v[DL +: DWD] = bus.tuple_out_DATA[DWD-1:0];
    return v;
  endfunction

  function automatic logic gate_m();
    return in_sop_m && q.size() == DEPTH;
  endfunction

  always @(posedge clk) begin
    logic ia, oa;
    if (rst) begin
      q.delete();
      in_sop_m = 1; out_sop_m = 1; uf_m = 0; hold_m = '0;
    end else begin
      ia = bus.s_axis_tvalid && bus.proc_in_tready && !gate_m();
      oa = bus.m_axis_tvalid && bus.m_axis_tready;
      if (oa && out_sop_m) begin
        hold_m = live_m();
        if (q.size() == 0) uf_m = 1;
        else void'(q.pop_front());
      end
      if (ia && in_sop_m) q.push_back(bus.s_axis_tuser);
      if (ia) in_sop_m = bus.s_axis_tlast;
      if (oa) out_sop_m = bus.m_axis_tlast;
    end
  end

  always @(negedge clk) begin
    logic g, p;
    if (!rst) begin
      g = gate_m();
      p = bus.s_axis_tvalid && bus.proc_in_tready && !g && in_sop_m;
      chk("s_axis_tready", PW'(bus.s_axis_tready), PW'(bus.proc_in_tready && !g));
      chk("proc_in_tvalid", PW'(bus.proc_in_tvalid), PW'(bus.s_axis_tvalid && !g));
      chk("tuple_in_VALID", PW'(bus.tuple_in_VALID), PW'(p));
      chk("tuple_in_DATA", bus.tuple_in_DATA, p ? PW'(bus.s_axis_tuser) : '0);
      chk("m_axis_tuser", PW'(bus.m_axis_tuser), PW'(out_sop_m ? live_m() : hold_m));
      chk("fifo_count", PW'(bus.fifo_count), PW'(q.size()));
      chk("underflow_err", PW'(bus.underflow_err), PW'(uf_m));
    end
  end

  task automatic step(); @(posedge clk); #1; endtask

  task automatic idle();
    bus.s_axis_tvalid = 0; bus.s_axis_tlast = 0; bus.proc_in_tready = 1;
    bus.m_axis_tvalid = 0; bus.m_axis_tready = 1; bus.m_axis_tlast = 0;
    bus.tuple_out_VALID = 0; bus.tuple_out_DATA = '0;
  endtask

  task automatic do_reset(); rst = 1; idle(); step(); rst = 0; endtask

  task automatic in_beat(input logic [TW-1:0] u, input logic last);
    bus.s_axis_tvalid = 1; bus.s_axis_tuser = u; bus.s_axis_tlast = last;
    step();
    bus.s_axis_tvalid = 0;
  endtask

  task automatic out_beat(input string name, input logic last, input logic [TW-1:0] exp);
    bus.m_axis_tvalid = 1; bus.m_axis_tlast = last;
    @(negedge clk);
    chk(name, PW'(bus.m_axis_tuser), PW'(exp));
    step();
    bus.m_axis_tvalid = 0;
  endtask

  initial begin
    bus.s_axis_tuser = '0;
    idle();
    do_reset();
    @(negedge clk);
    chk("rst_m_tuser", PW'(bus.m_axis_tuser), '0);
    chk("rst_count", PW'(bus.fifo_count), '0);
    chk("rst_underflow", PW'(bus.underflow_err), '0);
    step();
    // ordering: 1, 2 and 4 beat packets, output side 20 cycles later
    in_beat(64'h11, 1);
    in_beat(64'h22, 0); in_beat(64'h22, 1);
    for (int i = 0; i < 4; i++) in_beat(64'h33, i == 3);
    repeat (13) step();
    @(negedge clk);
    chk("ord_peak", PW'(bus.fifo_count), PW'(3));
    step();
    out_beat("ord_p1", 1, 64'h11);
    out_beat("ord_p2b0", 0, 64'h22); out_beat("ord_p2b1", 1, 64'h22);
    for (int i = 0; i < 4; i++) out_beat("ord_p3", i == 3, 64'h33);
    @(negedge clk);
    chk("ord_drained", PW'(bus.fifo_count), '0);
    step();
    // tuple strobe only on the SOP beat
    bus.s_axis_tvalid = 1; bus.s_axis_tuser = 64'hAB; bus.s_axis_tlast = 0;
    @(negedge clk);
    chk("tup_sop_valid", PW'(bus.tuple_in_VALID), PW'(1));
    chk("tup_sop_data", bus.tuple_in_DATA, PW'(64'hAB));
    step();
    bus.s_axis_tlast = 1;
    @(negedge clk);
    chk("tup_mid_valid", PW'(bus.tuple_in_VALID), '0);
    chk("tup_mid_data", bus.tuple_in_DATA, '0);
    step();
    // full backpressure on the 5th SOP
    do_reset();
    for (int i = 1; i <= 4; i++) in_beat(TW'(i), 1);
    bus.s_axis_tvalid = 1; bus.s_axis_tuser = 64'h55; bus.s_axis_tlast = 1;
    bus.m_axis_tvalid = 1; bus.m_axis_tlast = 1;
    @(negedge clk);
    chk("full_tready", PW'(bus.s_axis_tready), '0);
    chk("full_tvalid", PW'(bus.proc_in_tvalid), '0);
    chk("full_count", PW'(bus.fifo_count), PW'(4));
    step();
    bus.m_axis_tvalid = 0;
    @(negedge clk);
    chk("full_release", PW'(bus.s_axis_tready), PW'(1));
    chk("full_tuple", PW'(bus.tuple_in_VALID), PW'(1));
    step();
    bus.s_axis_tvalid = 0;
    @(negedge clk);
    chk("full_refill", PW'(bus.fifo_count), PW'(4));
    step();
    // dst-port override, held across the packet
    do_reset();
    in_beat(64'h0000_0000_0100_0000, 1);
    bus.tuple_out_VALID = 1; bus.tuple_out_DATA = 128'hABCD_1204;
    out_beat("ovr_sop", 0, 64'h0000_0000_0400_0000);
    bus.tuple_out_VALID = 0;
    out_beat("ovr_hold", 1, 64'h0000_0000_0400_0000);
    // underflow
    do_reset();
    out_beat("uf_tuser", 1, '0);
    @(negedge clk);
    chk("uf_flag", PW'(bus.underflow_err), PW'(1));
    chk("uf_count", PW'(bus.fifo_count), '0);
    repeat (3) step();
    @(negedge clk);
    chk("uf_sticky", PW'(bus.underflow_err), PW'(1));
    step();
    // reset during beat 2 of a 3-beat packet
    do_reset();
    in_beat(64'h1, 1);
    in_beat(64'h2, 0);
    bus.s_axis_tvalid = 1; bus.s_axis_tuser = 64'h3; bus.s_axis_tlast = 0; rst = 1;
    step();
    rst = 0; bus.s_axis_tvalid = 0;
    @(negedge clk);
    chk("rstmid_count", PW'(bus.fifo_count), '0);
    chk("rstmid_tuple", PW'(bus.tuple_in_VALID), '0);
    step();
    bus.s_axis_tvalid = 1; bus.s_axis_tuser = 64'h77;
    @(negedge clk);
    chk("rstmid_sop", bus.tuple_in_DATA, PW'(64'h77));
    step();
    bus.s_axis_tvalid = 0;
    @(negedge clk);
    chk("rstmid_push", PW'(bus.fifo_count), PW'(1));
    step();
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      bus.s_axis_tvalid = $urandom_range(0, 1);
      bus.s_axis_tlast = ($urandom_range(0, 2) == 0);
      bus.s_axis_tuser = {$urandom, $urandom};
      bus.proc_in_tready = ($urandom_range(0, 3) != 0);
      bus.m_axis_tvalid = ($urandom_range(0, 9) < 4);
      bus.m_axis_tready = ($urandom_range(0, 3) != 0);
      bus.m_axis_tlast = ($urandom_range(0, 2) == 0);
      bus.tuple_out_VALID = $urandom_range(0, 1);
      bus.tuple_out_DATA = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    rst = 0;
    idle();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
